load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 206 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RISC-V style load or store at a time, talks to a
// word-wide data memory without byte enables, and returns a one-cycle response.
//   CLK, RST              : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake, accepted only in IDLE
//   req_we, req_funct3    : store/load select and access size/extension
//   req_addr, req_wdata   : byte address and store data (low bytes used)
//   rsp_valid, rsp_rdata  : completion pulse and extended load data
//   rsp_err               : misaligned or illegal access, valid with rsp_valid
//   mem_addr/wdata/wr     : word-aligned memory request, mem_wr pulses once per store
//   mem_rdata             : memory read data, sampled on the last READ cycle
module load_store_unit #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_wr,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int unsigned OFFW = $clog2(XLEN / 8);
    localparam int unsigned CNTW = $clog2(MEM_LAT + 1);
    localparam int unsigned SHW  = OFFW + 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic              mem_wr_q, mem_wr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              we_q, we_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    logic              accept;
    logic              misaligned;
    logic              req_err;
    logic              full_store;
    logic              last_rd;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   rd_shift;
    logic [XLEN-1:0]   load_ext;
    logic [XLEN-1:0]   lane_mask;
    logic [XLEN-1:0]   merged;

    assign accept  = req_valid & ready_q;
    assign last_rd = (cnt_q == CNTW'(MEM_LAT - 1));

    // Request classification, evaluated on the incoming request at accept time
    always_comb begin
        misaligned = 1'b0;
        case (req_funct3[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
        req_err = misaligned
                | (req_funct3 == 3'd7)
                | ((XLEN == 32) && ((req_funct3 == 3'd3) || (req_funct3 == 3'd6)))
                | (req_we && req_funct3[2]);
        full_store = req_we && ((XLEN == 64) ? (req_funct3 == 3'd3) : (req_funct3 == 3'd2));
    end

    // Byte-lane extraction for loads and lane merge for sub-width stores
    always_comb begin
        shamt    = {addr_q[OFFW-1:0], 3'b000};
        rd_shift = mem_rdata >> shamt;
        case (funct3_q)
            3'd0:    load_ext = XLEN'($signed(rd_shift[7:0]));
            3'd1:    load_ext = XLEN'($signed(rd_shift[15:0]));
            3'd2:    load_ext = XLEN'($signed(rd_shift[31:0]));
            3'd4:    load_ext = XLEN'(rd_shift[7:0]);
            3'd5:    load_ext = XLEN'(rd_shift[15:0]);
            3'd6:    load_ext = XLEN'(rd_shift[31:0]);
            default: load_ext = rd_shift;
        endcase
        case (funct3_q[1:0])
            2'd0:    lane_mask = XLEN'(8'hFF);
            2'd1:    lane_mask = XLEN'(16'hFFFF);
            2'd2:    lane_mask = XLEN'(32'hFFFF_FFFF);
            default: lane_mask = '1;
        endcase
        lane_mask = lane_mask << shamt;
        merged    = (mem_rdata & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)         state_d = RESP;
                    else if (full_store) state_d = WRITE;
                    else                 state_d = READ;
                end
            end
            READ:    if (last_rd) state_d = we_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; status outputs follow the next state so
    // they line up with the state they describe
    always_comb begin
        ready_d     = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        mem_wr_d    = (state_d == WRITE);
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        mem_wdata_d = mem_wdata_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    funct3_d    = req_funct3;
                    we_d        = req_we;
                    cnt_d       = '0;
                    mem_wdata_d = req_wdata;
                    if (req_err) begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            READ: begin
                cnt_d = cnt_q + CNTW'(1);
                if (last_rd) begin
                    if (we_q) mem_wdata_d = merged;
                    else      rsp_rdata_d = load_ext;
                end
            end
            WRITE:   rsp_rdata_d = '0;
            default: ;
        endcase
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_addr  = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: a 64-bit / latency-1 unit and a 32-bit / latency-3 unit,
// each with a small word memory.
module tb_load_store_unit;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST;
    logic mem_init;
    int   total = 0;
    int   bad   = 0;

    // 64-bit, MEM_LAT=1 instance
    logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_err, a_mem_wr;
    logic [2:0]  a_f3;
    logic [63:0] a_addr, a_wdata, a_rsp_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [63:0] mem64 [0:63];

    load_store_unit #(.XLEN(64), .MEM_LAT(1)) u_dut64 (
        .CLK(CLK), .RST(RST),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_funct3(a_f3), .req_addr(a_addr), .req_wdata(a_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wr(a_mem_wr),
        .mem_rdata(a_mem_rdata)
    );

    assign a_mem_rdata = mem64[a_mem_addr[8:3]];
    always @(posedge CLK) begin
        if (mem_init)      mem64[6'h20] <= 64'h8877665544332211;
        else if (a_mem_wr) mem64[a_mem_addr[8:3]] <= a_mem_wdata;
    end

    // 32-bit, MEM_LAT=3 instance
    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_err, b_mem_wr;
    logic [2:0]  b_f3;
    logic [31:0] b_addr, b_wdata, b_rsp_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [31:0] mem32 [0:63];

    load_store_unit #(.XLEN(32), .MEM_LAT(3)) u_dut32 (
        .CLK(CLK), .RST(RST),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_funct3(b_f3), .req_addr(b_addr), .req_wdata(b_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wr(b_mem_wr),
        .mem_rdata(b_mem_rdata)
    );

    assign b_mem_rdata = mem32[b_mem_addr[7:2]];
    always @(posedge CLK) begin
        if (mem_init)      mem32[6'h00] <= 32'h88776655;
        else if (b_mem_wr) mem32[b_mem_addr[7:2]] <= b_mem_wdata;
    end

    // Issues one request to the 64-bit unit and records response/write cycles
    // (cycle 0 is the accepting edge; 0 in rcyc means no response within bound)
    task automatic run64(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, output int rcyc, output int wcyc,
                         output int wcnt, output logic err, output logic [63:0] rdata,
                         output logic [63:0] wd);
        rcyc = 0; wcyc = 0; wcnt = 0; err = 1'b0; rdata = '0; wd = '0;
        @(negedge CLK);
        a_req_valid = 1'b1; a_req_we = we; a_f3 = f3; a_addr = addr; a_wdata = wdata;
        @(posedge CLK);
        #1 a_req_valid = 1'b0;
        for (int c = 1; c <= 20 && rcyc == 0; c++) begin
            @(negedge CLK);
            if (a_mem_wr === 1'b1) begin wcnt++; wcyc = c; wd = a_mem_wdata; end
            if (a_rsp_valid === 1'b1) begin rcyc = c; err = a_rsp_err; rdata = a_rsp_rdata; end
        end
    endtask

    task automatic run32(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int rcyc, output int wcyc,
                         output int wcnt, output logic err, output logic [31:0] rdata,
                         output logic [31:0] wd);
        rcyc = 0; wcyc = 0; wcnt = 0; err = 1'b0; rdata = '0; wd = '0;
        @(negedge CLK);
        b_req_valid = 1'b1; b_req_we = we; b_f3 = f3; b_addr = addr; b_wdata = wdata;
        @(posedge CLK);
        #1 b_req_valid = 1'b0;
        for (int c = 1; c <= 20 && rcyc == 0; c++) begin
            @(negedge CLK);
            if (b_mem_wr === 1'b1) begin wcnt++; wcyc = c; wd = b_mem_wdata; end
            if (b_rsp_valid === 1'b1) begin rcyc = c; err = b_rsp_err; rdata = b_rsp_rdata; end
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; mem_init = 1'b1;
        #1;
        total++; if (a_req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", a_req_ready); end
        total++; if ({a_rsp_valid, a_rsp_err, a_mem_wr} !== 3'b000) begin bad++; $display("FAIL reset_flags got %b want 000", {a_rsp_valid, a_rsp_err, a_mem_wr}); end
        total++; if ({a_rsp_rdata, a_mem_addr, a_mem_wdata} !== '0) begin bad++; $display("FAIL reset_data got %h %h %h want 0", a_rsp_rdata, a_mem_addr, a_mem_wdata); end
        repeat (2) @(negedge CLK);
        RST = 1'b1; mem_init = 1'b0;
        @(posedge CLK); #1;
        total++; if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin bad++; $display("FAIL release_ready got %b%b want 11", a_req_ready, b_req_ready); end
    endtask

    task automatic test_loads();
        int rc, wc, wn; logic e; logic [63:0] rd, wd;
        run64(1'b0, 3'd0, 64'h107, 64'h0, rc, wc, wn, e, rd, wd);
        total++; if (rc !== 2 || e !== 1'b0) begin bad++; $display("FAIL lb_timing got cyc=%0d err=%b want 2 0", rc, e); end
        total++; if (rd !== 64'hFFFFFFFFFFFFFF88) begin bad++; $display("FAIL lb_data got %h want FFFFFFFFFFFFFF88", rd); end
        run64(1'b0, 3'd4, 64'h107, 64'h0, rc, wc, wn, e, rd, wd);
        total++; if (rd !== 64'h88 || rc !== 2) begin bad++; $display("FAIL lbu got %h cyc=%0d want 88 2", rd, rc); end
        run64(1'b0, 3'd2, 64'h104, 64'h0, rc, wc, wn, e, rd, wd);
        total++; if (rd !== 64'hFFFFFFFF88776655 || wn !== 0) begin bad++; $display("FAIL lw got %h wr=%0d want FFFFFFFF88776655 0", rd, wn); end
        repeat (3) @(negedge CLK);
        total++; if (a_rsp_rdata !== 64'hFFFFFFFF88776655 || a_rsp_valid !== 1'b0 || a_rsp_err !== 1'b0) begin
            bad++; $display("FAIL rdata_hold got %h v=%b e=%b want FFFFFFFF88776655 0 0", a_rsp_rdata, a_rsp_valid, a_rsp_err); end
    endtask

    task automatic test_sub_store();
        int rc, wc, wn; logic e; logic [63:0] rd, wd;
        run64(1'b1, 3'd1, 64'h102, 64'hBEEF, rc, wc, wn, e, rd, wd);
        total++; if (wc !== 2 || wn !== 1 || rc !== 3) begin bad++; $display("FAIL sh_timing got wr=%0d n=%0d rsp=%0d want 2 1 3", wc, wn, rc); end
        total++; if (wd !== 64'h88776655BEEF2211) begin bad++; $display("FAIL sh_wdata got %h want 88776655BEEF2211", wd); end
        total++; if (rd !== 64'h0 || e !== 1'b0) begin bad++; $display("FAIL sh_rsp got %h err=%b want 0 0", rd, e); end
    endtask

    task automatic test_full_store();
        int rc, wc, wn; logic e; logic [63:0] rd, wd;
        run64(1'b1, 3'd3, 64'h100, 64'h0123456789ABCDEF, rc, wc, wn, e, rd, wd);
        total++; if (wc !== 1 || wn !== 1 || rc !== 2 || e !== 1'b0) begin bad++; $display("FAIL sd_timing got wr=%0d n=%0d rsp=%0d err=%b want 1 1 2 0", wc, wn, rc, e); end
        total++; if (wd !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL sd_wdata got %h want 0123456789ABCDEF", wd); end
        run64(1'b0, 3'd3, 64'h100, 64'h0, rc, wc, wn, e, rd, wd);
        total++; if (rd !== 64'h0123456789ABCDEF || rc !== 2) begin bad++; $display("FAIL ld got %h cyc=%0d want 0123456789ABCDEF 2", rd, rc); end
        run64(1'b0, 3'd0, 64'h100, 64'h0, rc, wc, wn, e, rd, wd);
        total++; if (rd !== 64'hFFFFFFFFFFFFFFEF) begin bad++; $display("FAIL lb0 got %h want FFFFFFFFFFFFFFEF", rd); end
        run64(1'b0, 3'd6, 64'h104, 64'h0, rc, wc, wn, e, rd, wd);
        total++; if (rd !== 64'h0000000001234567) begin bad++; $display("FAIL lwu got %h want 0000000001234567", rd); end
        run64(1'b0, 3'd5, 64'h106, 64'h0, rc, wc, wn, e, rd, wd);
        total++; if (rd !== 64'h0123) begin bad++; $display("FAIL lhu got %h want 0123", rd); end
    endtask

    task automatic test_errors();
        int rc, wc, wn; logic e; logic [63:0] rd, wd;
        run64(1'b0, 3'd2, 64'h102, 64'h0, rc, wc, wn, e, rd, wd);
        total++; if (rc !== 1 || e !== 1'b1 || rd !== 64'h0 || wn !== 0) begin bad++; $display("FAIL lw_misalign got cyc=%0d err=%b rd=%h wr=%0d want 1 1 0 0", rc, e, rd, wn); end
        run64(1'b0, 3'd7, 64'h100, 64'h0, rc, wc, wn, e, rd, wd);
        total++; if (rc !== 1 || e !== 1'b1 || rd !== 64'h0 || wn !== 0) begin bad++; $display("FAIL f3_7 got cyc=%0d err=%b rd=%h wr=%0d want 1 1 0 0", rc, e, rd, wn); end
        run64(1'b1, 3'd4, 64'h100, 64'h55, rc, wc, wn, e, rd, wd);
        total++; if (rc !== 1 || e !== 1'b1 || wn !== 0) begin bad++; $display("FAIL store_f3_4 got cyc=%0d err=%b wr=%0d want 1 1 0", rc, e, wn); end
        @(negedge CLK);
        total++; if (a_rsp_err !== 1'b0) begin bad++; $display("FAIL err_clear got %b want 0", a_rsp_err); end
    endtask

    task automatic test_reset_abort();
        int seen;
        seen = 0;
        @(negedge CLK);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_f3 = 3'd0; a_addr = 64'h101; a_wdata = 64'hAA;
        @(posedge CLK);
        #1 a_req_valid = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        total++; if ({a_req_ready, a_rsp_valid, a_mem_wr} !== 3'b000 || a_mem_addr !== 64'h0) begin
            bad++; $display("FAIL abort_outputs got %b addr=%h want 000 0", {a_req_ready, a_rsp_valid, a_mem_wr}, a_mem_addr); end
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            if (a_mem_wr !== 1'b0 || a_rsp_valid !== 1'b0) seen++;
        end
        RST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            if (a_mem_wr !== 1'b0 || a_rsp_valid !== 1'b0) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_activity got %0d want 0", seen); end
        total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got %b want 1", a_req_ready); end
        total++; if (mem64[6'h20] !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL abort_mem got %h want 0123456789ABCDEF", mem64[6'h20]); end
    endtask

    task automatic test_xlen32();
        int rc, wc, wn; logic e; logic [31:0] rd, wd;
        run32(1'b0, 3'd3, 32'h100, 32'h0, rc, wc, wn, e, rd, wd);
        total++; if (rc !== 1 || e !== 1'b1) begin bad++; $display("FAIL x32_ld got cyc=%0d err=%b want 1 1", rc, e); end
        run32(1'b0, 3'd6, 32'h100, 32'h0, rc, wc, wn, e, rd, wd);
        total++; if (rc !== 1 || e !== 1'b1) begin bad++; $display("FAIL x32_lwu got cyc=%0d err=%b want 1 1", rc, e); end
        run32(1'b0, 3'd1, 32'h102, 32'h0, rc, wc, wn, e, rd, wd);
        total++; if (rc !== 4 || e !== 1'b0 || rd !== 32'hFFFF8877) begin bad++; $display("FAIL x32_lh got cyc=%0d err=%b rd=%h want 4 0 FFFF8877", rc, e, rd); end
        run32(1'b1, 3'd0, 32'h101, 32'hAA, rc, wc, wn, e, rd, wd);
        total++; if (wc !== 4 || rc !== 5 || wd !== 32'h8877AA55) begin bad++; $display("FAIL x32_sb got wr=%0d rsp=%0d wd=%h want 4 5 8877AA55", wc, rc, wd); end
        run32(1'b1, 3'd2, 32'h100, 32'hCAFEF00D, rc, wc, wn, e, rd, wd);
        total++; if (wc !== 1 || rc !== 2 || wd !== 32'hCAFEF00D) begin bad++; $display("FAIL x32_sw got wr=%0d rsp=%0d wd=%h want 1 2 CAFEF00D", wc, rc, wd); end
    endtask

    initial begin
        a_req_valid = 1'b0; a_req_we = 1'b0; a_f3 = '0; a_addr = '0; a_wdata = '0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_f3 = '0; b_addr = '0; b_wdata = '0;
        test_reset();
        test_loads();
        test_sub_store();
        test_full_store();
        test_errors();
        test_xlen32();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
